// File: rtl/sha256_padder_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

    // Padder FSM states; the encoding is visible on the debug state port.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_PAD  = 3'd2,
        ST_LEN  = 3'd3,
        ST_WAIT = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    localparam int         CHUNK_WORDS = 16;
    localparam int         WCNT_W      = $clog2(CHUNK_WORDS);
    localparam logic [3:0] LEN_WORD_HI = 4'd14;
    localparam logic [3:0] LEN_WORD_LO = 4'd15;
    localparam logic [7:0] PAD_BYTE    = 8'h80;

    // The core byte-swaps every word it takes in, so the length words are
    // pre-swapped here to come out big-endian inside the core.
    function automatic logic [31:0] byteswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sha256_padder_if.sv
// Upstream message word stream into the padder.
//
// Handshake: a word transfers on a rising clk edge where s_valid_i and
// s_ready_o are both 1. While s_valid_i is 1 and the word has not been
// taken, the producer holds s_data_i/s_bytes_i/s_last_i stable. s_ready_o
// may rise or fall independently of s_valid_i.
interface sha256_padder_if;
    logic        s_valid_i;
    logic [31:0] s_data_i;
    logic [2:0]  s_bytes_i;
    logic        s_last_i;
    logic        s_ready_o;

    modport master (
        output s_valid_i, s_data_i, s_bytes_i, s_last_i,
        input  s_ready_o
    );

    modport slave (
        input  s_valid_i, s_data_i, s_bytes_i, s_last_i,
        output s_ready_o
    );
endinterface

// File: rtl/sha256_padder_pad_word.sv
// Final-word formatter: zeroes lanes above the byte count and drops the
// 0x80 marker into the first unused lane. Full or non-final words pass through.
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  nbytes_i,
    input  logic        last_i,
    output logic [31:0] word_o
);

    // Per-lane select: keep message byte, insert marker, or zero.
    always_comb begin
        word_o = data_i;
        if (last_i && (nbytes_i < 3'd4)) begin
            for (int i = 0; i < 4; i++) begin
                if (i < int'(nbytes_i)) begin
                    word_o[8*i +: 8] = data_i[8*i +: 8];
                end else if (i == int'(nbytes_i)) begin
                    word_o[8*i +: 8] = PAD_BYTE;
                end else begin
                    word_o[8*i +: 8] = 8'h00;
                end
            end
        end
    end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 padder: forwards message words, appends 0x80, zero fill and the
// 64-bit bit length, and paces 16-word chunks on the core's finish pulse.
module sha256_padder
    import sha256_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    sha256_padder_if.slave    s,
    output logic              dat_vaild_o,
    output logic [31:0]       dat_lsb_o,
    input  logic              hash_busy_i,
    input  logic              irq_finish_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [2:0]        dbg_state_o
);

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [63:0]         bitlen_q, bitlen_d;
    logic                owed_q, owed_d;          // 0x80 marker not yet emitted
    logic                last_seen_q, last_seen_d;  // final message word taken
    logic                final_q, final_d;        // length words emitted
    logic                s_ready_q, s_ready_d;
    logic                vld_q, vld_d;
    logic [31:0]         lsb_q, lsb_d;

    logic                accept;
    logic                emit;
    logic [31:0]         emit_word;
    logic [31:0]         fmt_word;
    logic [63:0]         bit_inc;

    sha256_pad_word u_pad_word (
        .data_i   (s.s_data_i),
        .nbytes_i (s.s_bytes_i),
        .last_i   (s.s_last_i),
        .word_o   (fmt_word)
    );

    // A busy core while we would be feeding it is a protocol error: stall.
    assign s.s_ready_o = s_ready_q & ~hash_busy_i;
    assign accept      = s.s_valid_i & s.s_ready_o;
    assign bit_inc     = {58'd0, s.s_bytes_i, 3'b000};

    assign dat_vaild_o = vld_q;
    assign dat_lsb_o   = lsb_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign dbg_state_o = state_q;

    // Next-state, word selection and chunk bookkeeping.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        bitlen_d    = bitlen_q;
        owed_d      = owed_q;
        last_seen_d = last_seen_q;
        final_d     = final_q;
        vld_d       = 1'b0;
        lsb_d       = lsb_q;
        emit        = 1'b0;
        emit_word   = 32'h0;

        case (state_q)
            ST_IDLE, ST_DATA: begin
                if (accept) begin
                    emit        = 1'b1;
                    emit_word   = fmt_word;
                    last_seen_d = s.s_last_i;
                    owed_d      = s.s_last_i & s.s_bytes_i[2];
                    if (state_q == ST_IDLE) begin
                        bitlen_d = bit_inc;
                        final_d  = 1'b0;
                    end else begin
                        bitlen_d = bitlen_q + bit_inc;
                    end
                end
            end
            ST_PAD: begin
                if (!hash_busy_i) begin
                    emit      = 1'b1;
                    emit_word = owed_q ? {24'h0, PAD_BYTE} : 32'h0;
                    owed_d    = 1'b0;
                end
            end
            ST_LEN: begin
                if (!hash_busy_i) begin
                    emit      = 1'b1;
                    emit_word = (wcnt_q == LEN_WORD_HI) ? byteswap(bitlen_q[63:32])
                                                         : byteswap(bitlen_q[31:0]);
                    if (wcnt_q == LEN_WORD_LO) begin
                        final_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (irq_finish_i) begin
                    if (final_q) begin
                        state_d = ST_DONE;
                    end else if (!last_seen_q) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_PAD;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (emit) begin
            vld_d  = 1'b1;
            lsb_d  = emit_word;
            wcnt_d = wcnt_q + WCNT_W'(1);
            if (wcnt_d == '0) begin
                state_d = ST_WAIT;
            end else if (state_q == ST_LEN) begin
                state_d = ST_LEN;
            end else if (last_seen_d && !owed_d && (wcnt_d == LEN_WORD_HI)) begin
                state_d = ST_LEN;
            end else if (last_seen_d) begin
                state_d = ST_PAD;
            end else begin
                state_d = ST_DATA;
            end
        end

        s_ready_d = (state_d == ST_IDLE) || (state_d == ST_DATA);
    end

    // State and output registers; reset returns everything to idle zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            bitlen_q    <= 64'h0;
            owed_q      <= 1'b0;
            last_seen_q <= 1'b0;
            final_q     <= 1'b0;
            s_ready_q   <= 1'b0;
            vld_q       <= 1'b0;
            lsb_q       <= 32'h0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            bitlen_q    <= bitlen_d;
            owed_q      <= owed_d;
            last_seen_q <= last_seen_d;
            final_q     <= final_d;
            s_ready_q   <= s_ready_d;
            vld_q       <= vld_d;
            lsb_q       <= lsb_d;
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: directed messages, expected chunk words queued
// by the driver and checked by a monitor; a small core model pulses irq.
module tb_sha256_padder;

    logic        clk;
    logic        rst_n;
    logic        dat_vaild_o;
    logic [31:0] dat_lsb_o;
    logic        hash_busy_i;
    logic        irq_finish_i;
    logic        busy_o;
    logic        done_o;
    logic [2:0]  dbg_state_o;

    sha256_padder_if sif ();

    sha256_padder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s            (sif.slave),
        .dat_vaild_o  (dat_vaild_o),
        .dat_lsb_o    (dat_lsb_o),
        .hash_busy_i  (hash_busy_i),
        .irq_finish_i (irq_finish_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .dbg_state_o  (dbg_state_o)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    int          exp_chunks = 1;
    int          done_count = 0;
    logic        hold_mode  = 1'b0;

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] pat(input int k);
        logic [31:0] w;
        w = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
        return w;
    endfunction

    // Driver tasks
    task automatic send_word(input logic [31:0] data, input logic [2:0] nb, input logic last);
        logic r;
        int   cyc;
        sif.s_valid_i = 1'b1;
        sif.s_data_i  = data;
        sif.s_bytes_i = nb;
        sif.s_last_i  = last;
        cyc = 0;
        r   = 1'b0;
        while (!r && cyc < 1000) begin
            @(negedge clk);
            r = sif.s_ready_o;
            @(posedge clk);
            #1;
            cyc++;
        end
        sif.s_valid_i = 1'b0;
        if (!r) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_fwd(input int k);
        exp_q.push_back(pat(k));
        send_word(pat(k), 3'd4, 1'b0);
    endtask

    task automatic push_zeros(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(32'h0);
    endtask

    task automatic wait_done(input string name);
        int start;
        logic got;
        start = done_count;
        got   = 1'b0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(posedge clk);
            if (done_count != start) got = 1'b1;
        end
        check({name, "_done_seen"}, 64'(got), 64'd1);
        @(negedge clk);
        check({name, "_idle_busy"}, 64'(busy_o), 64'd0);
        check({name, "_idle_ready"}, 64'(sif.s_ready_o), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every emitted word must match the queue head
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && dat_vaild_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", dat_lsb_o);
                end else begin
                    check("chunk_word", 64'(dat_lsb_o), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // Core model: after 16 words, wait, pulse irq_finish, then check done_o
    initial begin
        int   cnt;
        int   chunk;
        int   dly;
        logic hold_ok;
        logic last_chunk;
        cnt = 0;
        chunk = 0;
        irq_finish_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cnt = 0;
                chunk = 0;
                continue;
            end
            if (dat_vaild_o) cnt++;
            if (cnt == 16) begin
                cnt = 0;
                chunk++;
                dly = hold_mode ? 50 : 2;
                hold_ok = 1'b1;
                for (int i = 0; i < dly; i++) begin
                    @(negedge clk);
                    if (sif.s_ready_o || dat_vaild_o) hold_ok = 1'b0;
                end
                if (hold_mode) check("hold_idle", 64'(hold_ok), 64'd1);
                @(posedge clk);
                #1 irq_finish_i = 1'b1;
                @(posedge clk);
                #1 irq_finish_i = 1'b0;
                @(negedge clk);
                last_chunk = (chunk == exp_chunks);
                check("done_after_irq", 64'(done_o), 64'(last_chunk));
                if (hold_mode) begin
                    check("resume_ready", 64'(sif.s_ready_o), 64'd1);
                    hold_mode = 1'b0;
                end
                if (last_chunk) begin
                    chunk = 0;
                    done_count++;
                end
            end
        end
    end

    // Directed scenarios
    initial begin
        rst_n = 1'b0;
        hash_busy_i = 1'b0;
        sif.s_valid_i = 1'b0;
        sif.s_data_i = 32'h0;
        sif.s_bytes_i = 3'd0;
        sif.s_last_i = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(sif.s_ready_o), 64'd0);
        check("rst_vaild", 64'(dat_vaild_o), 64'd0);
        check("rst_lsb", 64'(dat_lsb_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", 64'(sif.s_ready_o), 64'd1);
        @(posedge clk);
        #1;

        // "abc"
        exp_chunks = 1;
        exp_q.push_back(32'h80636261);
        push_zeros(14);
        exp_q.push_back(32'h18000000);
        send_word(32'h00636261, 3'd3, 1'b1);
        wait_done("abc");

        // Empty message; lanes of a zero-byte word are ignored
        exp_chunks = 1;
        exp_q.push_back(32'h00000080);
        push_zeros(15);
        send_word(32'hDEADBEEF, 3'd0, 1'b1);
        wait_done("empty");

        // 55 bytes: marker in lane 3 of word 13, one chunk
        exp_chunks = 1;
        for (int k = 0; k < 13; k++) send_fwd(k);
        exp_q.push_back(32'h80373635);
        exp_q.push_back(32'h00000000);
        exp_q.push_back(32'hb8010000);
        send_word(32'hAA373635, 3'd3, 1'b1);
        wait_done("len55");

        // 56 bytes: marker at word 14, length in an extra chunk
        exp_chunks = 2;
        for (int k = 0; k < 13; k++) send_fwd(k);
        exp_q.push_back(32'h38373635);
        exp_q.push_back(32'h00000080);
        push_zeros(16);
        exp_q.push_back(32'hc0010000);
        send_word(32'h38373635, 3'd4, 1'b1);
        wait_done("len56");

        // 80 bytes with a 50-cycle irq hold after the first chunk
        exp_chunks = 2;
        hold_mode  = 1'b1;
        for (int k = 0; k < 19; k++) send_fwd(k);
        exp_q.push_back(32'h504f4e4d);
        exp_q.push_back(32'h00000080);
        push_zeros(10);
        exp_q.push_back(32'h80020000);
        send_word(32'h504f4e4d, 3'd4, 1'b1);
        wait_done("len80_hold");

        // Async reset while word 7 of a chunk is on the output
        exp_chunks = 1;
        for (int k = 0; k < 8; k++) send_fwd(k);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_vaild", 64'(dat_vaild_o), 64'd0);
        check("midrst_lsb", 64'(dat_lsb_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_ready", 64'(sif.s_ready_o), 64'd0);
        check("midrst_done", 64'(done_o), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fresh "abc" after the reset
        exp_chunks = 1;
        exp_q.push_back(32'h80636261);
        push_zeros(14);
        exp_q.push_back(32'h18000000);
        send_word(32'h00636261, 3'd3, 1'b1);
        wait_done("abc_again");

        repeat (4) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sha256_padder.md
# sha256_padder

Upstream message-formatting stage for the `sha256` core. Accepts an arbitrary-length byte message as a 32-bit word stream with valid/ready handshake. Performs SHA-256 padding: 0x80 marker, zero fill, 64-bit big-endian bit length. Emits exactly 16-word chunks on the core's `dat_vaild_i`/`dat_lsb_i` port, pacing chunks on the core's completion pulse.

## Interface
- Parameters: none (chunk = 16 words, length field = 64 bits, fixed by SHA-256).
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `s_valid_i` in 1: input word valid.
- `s_data_i` in 32: message bytes, first byte in [7:0], fourth in [31:24].
- `s_bytes_i` in 3: valid bytes in word, 0–4.
  - Must be 4 unless `s_last_i`=1.
  - 0 is legal only with `s_last_i`=1.
  - Lanes above the count are ignored.
- `s_last_i` in 1: final word of message.
- `s_ready_o` out 1: word accepted when `s_valid_i & s_ready_o`.
- `dat_vaild_o` out 1: drives core `dat_vaild_i`.
- `dat_lsb_o` out 32: drives core `dat_lsb_i`, same lane order as `s_data_i`.
- `hash_busy_i` in 1: from core `hash_busy_o`.
- `irq_finish_i` in 1: from core `irq_finish`, 1-cycle pulse per chunk.
- `busy_o` out 1: message in progress (not IDLE).
- `done_o` out 1: 1-cycle pulse; final chunk compressed, core hash outputs valid.

## Operation
- States:
  - IDLE: `s_ready_o`=1.
  - DATA: forward input words.
  - PAD: emit 0x80 word or zero words.
  - LEN: emit length words 14 and 15.
  - WAIT: chunk sent, await `irq_finish_i`.
  - DONE: pulse `done_o`, return to IDLE.
- `wcnt`[3:0] counts words emitted in the current chunk; it wraps 15→0 on the 16th word.
- `bitlen`[63:0] is cleared on the first accepted word of a message and increments by 8·`s_bytes_i` per accepted word.
- Non-last accepted word (IDLE/DATA): forwarded unchanged.
- Last word with `s_bytes_i`=n<4: lanes ≥n zeroed, lane n=0x80; the 0x80 is placed.
- Last word with n=4: forwarded; 0x80 still owed, go to PAD.
- PAD: the first PAD word is 0x00000080 if the 0x80 is still owed; later words are 0.
  - When `wcnt`=14 and 0x80 already placed, go to LEN.
- If the 0x80 lands at `wcnt`=14 or 15, finish that chunk with zeros. Then, after WAIT, emit a full extra chunk: words 0–13 zero, then LEN.
- LEN: word 14 = byteswap(`bitlen`[63:32]); word 15 = byteswap(`bitlen`[31:0]).
- Byteswap makes the core's internal swap yield big-endian length.
- After the 16th word of any chunk, go to WAIT. `s_ready_o`=0 and `dat_vaild_o`=0.
- On `irq_finish_i`: next state is DONE if the final chunk has been sent. Otherwise resume DATA (message data still pending) or PAD/LEN (padding chunk pending).
- `s_ready_o`=1 only in IDLE/DATA with no pending output slot. It drops in the cycle a last word is accepted and in the cycle a 16th word is accepted.
- `hash_busy_i` high in IDLE/DATA/PAD/LEN is a protocol error; the padder holds outputs idle until it clears.
- Hash initial-value reload between messages belongs to the core/system, not this block.

## Timing
- Reset values: `s_ready_o`=0 in the reset cycle and 1 from the first clock in IDLE; `dat_vaild_o`=0, `dat_lsb_o`=0, `busy_o`=0, `done_o`=0.
- Internal: `wcnt`=0, `bitlen`=0.
- `dat_vaild_o`/`dat_lsb_o` are registered: a word accepted at edge N appears at N+1.
- Throughput: 1 word/cycle within a chunk. Input gaps produce output gaps; the core tolerates them.
- The next chunk's first `dat_vaild_o` comes no earlier than the cycle after `irq_finish_i`.
- `done_o` asserts the cycle after the final `irq_finish_i`.
- Simultaneous `s_valid_i` during WAIT/PAD/LEN/DONE: not accepted (`s_ready_o`=0).
- Async reset mid-chunk: immediate return to IDLE with all outputs 0. The core shares `rst_n`.

## Structure
- Package `sha256_pkg`:
  - state enum;
  - `CHUNK_WORDS`=16, `LEN_WORD_HI`=14, `LEN_WORD_LO`=15;
  - `PAD_BYTE`=8'h80;
  - byteswap function.
- Sub-module `sha256_pad_word`: combinational lane mask plus 0x80 insertion from (`s_data_i`, n); keeps the FSM readable.

## Test plan
- "abc": 0x00636261, n=3, last → words 0x80636261, 13×0, 0x00000000, 0x18000000. After `irq_finish_i`: `done_o`, core hash0=0xba7816bf.
- Empty message: n=0, last → word0 0x00000080, words 1–15 zero, one chunk, `done_o`. Core hash0=0xe3b0c442.
- 55-byte message → single chunk; 0x80 in lane 3 of word 13; word15=0xb8010000 (440 bits).
- 56-byte message → two chunks:
  - chunk1: word14=0x00000080, word15=0;
  - chunk2: words 0–14 zero, word15=0xc0010000.
- Hold `irq_finish_i` low 50 cycles after a 16th word → `s_ready_o`/`dat_vaild_o` stay 0; resume one cycle after the pulse.
- Deassert `rst_n` at word 7 of a chunk → outputs 0 immediately. A fresh "abc" then reproduces the first scenario.
